// File: rtl/ram_stream_reader.sv
// Burst reader: streams sequential words from a 1-cycle registered-read RAM onto a valid/ready port.
// Optional RAM_STREAM_READER_WRAP_EN adds cfg_wrap_addr_i for a circular address range.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
`ifdef RAM_STREAM_READER_WRAP_EN
  input  logic [ADDR_WIDTH-1:0] cfg_wrap_addr_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_read_en_o,
  output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_addr, w_addr_inc;
  logic [LEN_WIDTH-1:0]       r_remaining;
  logic                       r_inflight, r_inflight_last;
  logic [1:0][DATA_WIDTH-1:0] r_fifo_data;
  logic [1:0]                 r_fifo_last;
  logic                       r_wptr, r_rptr;
  logic [1:0]                 r_count;
  logic                       r_done;
`ifdef RAM_STREAM_READER_WRAP_EN
  logic [ADDR_WIDTH-1:0]      r_wrap;
`endif

  logic       w_pop, w_issue, w_accept, w_last_pop, w_last_issue;
  logic [2:0] w_occ;

  assign m_valid_o       = (r_count != 2'd0);
  assign m_data_o        = r_fifo_data[r_rptr];
  assign m_last_o        = m_valid_o & r_fifo_last[r_rptr];
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = r_done;
  assign ram_read_addr_o = r_addr;
  assign ram_read_en_o   = w_issue;

  assign w_pop        = m_valid_o & m_ready_i;
  assign w_last_pop   = w_pop & m_last_o;
  // Occupancy after this edge if no read is issued; keeping it below 2 leaves room for the new word.
  assign w_occ        = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue      = (r_state == S_RUN) && (r_remaining != '0) && (w_occ < 3'd2);
  assign w_last_issue = w_issue && (r_remaining == LEN_WIDTH'(1));
  assign w_accept     = (r_state == S_IDLE) && start_i && (length_i != '0);

`ifdef RAM_STREAM_READER_WRAP_EN
  assign w_addr_inc = (r_addr == r_wrap) ? '0 : r_addr + ADDR_WIDTH'(1);
`else
  assign w_addr_inc = r_addr + ADDR_WIDTH'(1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_pop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_data     <= '0;
      r_fifo_last     <= '0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= 2'd0;
      r_done          <= 1'b0;
`ifdef RAM_STREAM_READER_WRAP_EN
      r_wrap          <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= ((r_state == S_IDLE) && start_i && (length_i == '0)) ||
                 ((r_state == S_DRAIN) && w_last_pop);
      if (w_accept) begin
        r_addr      <= start_addr_i;
        r_remaining <= length_i;
`ifdef RAM_STREAM_READER_WRAP_EN
        r_wrap      <= cfg_wrap_addr_i;
`endif
      end else if (w_issue) begin
        r_addr      <= w_addr_inc;
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      // RAM output is only meaningful the cycle after a strobe
      if (r_inflight) begin
        r_fifo_data[r_wptr] <= ram_data_i;
        r_fifo_last[r_wptr] <= r_inflight_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: stimulus pushes expected reads/words, a negedge monitor checks them.
module tb_ram_stream_reader;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst, start_i, m_ready_i;
  logic [AW-1:0] start_addr_i;
  logic [LW-1:0] length_i;
  logic          busy_o, done_o, ram_read_en_o, m_valid_o, m_last_o;
  logic [AW-1:0] ram_read_addr_o;
  logic [DW-1:0] ram_data_i, m_data_o;
  logic [AW-1:0] wrap_cfg = 10'h3FF;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .start_addr_i(start_addr_i), .length_i(length_i),
`ifdef RAM_STREAM_READER_WRAP_EN
    .cfg_wrap_addr_i(wrap_cfg),
`endif
    .busy_o(busy_o), .done_o(done_o), .ram_read_en_o(ram_read_en_o),
    .ram_read_addr_o(ram_read_addr_o), .ram_data_i(ram_data_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o)
  );

  always #5 clk = ~clk;

  // RAM model: RAM[i] = i + 0x100, registered read every clock
  always @(posedge clk) ram_data_i <= 32'(ram_read_addr_o) + 32'h100;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [DW-1:0] d; logic l; } word_t;
  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            issued = 0, popped = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
`ifdef RAM_STREAM_READER_WRAP_EN
    return (a == wrap_cfg) ? '0 : a + 10'd1;
`else
    return a + 10'd1;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); addr_q.delete();
      issued = 0; popped = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_valid_o, 1'b1);
        chk("stall_data", m_data_o, prev_d);
        chk("stall_last", m_last_o, prev_l);
      end
      if (ram_read_en_o) begin
        issued++;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read actual=%0h required=none", ram_read_addr_o);
        end else chk("read_addr", ram_read_addr_o, addr_q.pop_front());
      end
      if (m_valid_o && m_ready_i) begin
        popped++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%0h required=none", m_data_o);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_data", m_data_o, w.d);
          chk("word_last", m_last_o, w.l);
        end
      end
      if (ram_read_en_o) chk("outstanding_le2", 64'(issued - popped > 2), 64'd0);
      prev_stall = m_valid_o && !m_ready_i;
      prev_d     = m_data_o;
      prev_l     = m_last_o;
    end
  end

  task automatic start_burst(input logic [AW-1:0] a, input logic [LW-1:0] n);
    logic [AW-1:0] x;
    x = a;
    for (int i = 0; i < int'(n); i++) begin
      word_t w;
      w.d = 32'(x) + 32'h100;
      w.l = (i == int'(n) - 1);
      addr_q.push_back(x);
      exp_q.push_back(w);
      x = nxt(x);
    end
    start_i = 1'b1; start_addr_i = a; length_i = n;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Returns at the negedge of the done_o cycle. pat 1 drives ready 1,0,0,1 repeating.
  task automatic wait_done(input int pat, input int max, input int poke);
    int c;
    c = 0;
    forever begin
      m_ready_i = (pat == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (c == poke) begin
        start_i = 1'b1; start_addr_i = 10'h200; length_i = 11'd5;
      end
      @(negedge clk);
      if (done_o) begin
        m_ready_i = 1'b1;
        return;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      c++;
      if (c >= max) begin
        checks++; errors++;
        $display("FAIL done_timeout actual=%0d required=<%0d", c, max);
        m_ready_i = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int first_v, done_c;
    logic busy_at_done;
    rst = 1'b1; start_i = 1'b0; m_ready_i = 1'b1; start_addr_i = '0; length_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_rd_en", ram_read_en_o, 1'b0);
    chk("rst_valid", m_valid_o, 1'b0);
    chk("rst_data", m_data_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // basic burst with cycle-exact latency
    start_burst(10'h010, 11'd4);
    first_v = -1; done_c = -1; busy_at_done = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("basic_busy_c1", busy_o, 1'b1);
        chk("basic_rd_en_c1", ram_read_en_o, 1'b1);
      end
      if (m_valid_o && first_v < 0) first_v = c;
      if (done_o) begin done_c = c; busy_at_done = busy_o; end
    end
    chk("basic_first_valid_cycle", 64'(first_v), 64'd3);
    chk("basic_done_cycle", 64'(done_c), 64'd7);
    chk("basic_busy_at_done", busy_at_done, 1'b0);
    @(posedge clk); #1;

    // backpressure
    start_burst(10'h080, 11'd8);
    wait_done(1, 200, -1);
    @(posedge clk); #1;

    // address wrap at 2**AW-1
    start_burst(10'h3FE, 11'd4);
    wait_done(0, 50, -1);
    @(posedge clk); #1;

`ifdef RAM_STREAM_READER_WRAP_EN
    wrap_cfg = 10'h00F;
    start_burst(10'h00E, 11'd3);
    wait_done(0, 50, -1);
    wrap_cfg = 10'h3FF;
    @(posedge clk); #1;
`endif

    // zero length
    start_burst(10'h050, 11'd0);
    @(negedge clk);
    chk("zero_done", done_o, 1'b1);
    chk("zero_busy", busy_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_pulse", done_o, 1'b0);
    @(posedge clk); #1;

    // start pulsed mid-burst is ignored
    start_burst(10'h0C0, 11'd6);
    wait_done(0, 50, 2);
    @(posedge clk); #1;

    // reset during word 3 of a len=8 burst
    start_burst(10'h100, 11'd8);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    chk("mid_rst_rd_en", ram_read_en_o, 1'b0);
    chk("mid_rst_addr", ram_read_addr_o, 10'h0);
    chk("mid_rst_valid", m_valid_o, 1'b0);
    chk("mid_rst_last", m_last_o, 1'b0);
    chk("mid_rst_data", m_data_o, 32'h0);
    @(posedge clk); #1;
    start_burst(10'h020, 11'd2);
    wait_done(0, 50, -1);
    @(posedge clk); #1;

    // back-to-back: second start in the done_o cycle
    start_burst(10'h030, 11'd3);
    wait_done(0, 50, -1);
    start_burst(10'h040, 11'd2);
    @(negedge clk);
    chk("b2b_rd_en", ram_read_en_o, 1'b1);
    chk("b2b_busy", busy_o, 1'b1);
    @(posedge clk); #1;
    wait_done(0, 50, -1);
    @(posedge clk); #1;

    chk("words_all_seen", 64'(exp_q.size()), 64'd0);
    chk("reads_all_seen", 64'(addr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "timeout");
  end

endmodule
